instr_fetch_decode: RTL and testbench

Front end of the multicycle CPU. It owns the program counter, fetches instruction words from instruction memory, and decodes MIPS fields into the command code the control state machine consumes. It hands each instruction to the controller with a valid/ready handshake. It then applies the controller's next-PC selection when the controller signals retirement.

---
 rtl/instr_fetch_decode.sv | 137 +++++++++++++
 tb/tb_instr_fetch_decode.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// Multicycle CPU front end: program counter, instruction fetch, MIPS field
// decode and valid/ready issue to the control state machine.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        ctrl_ready,
  input  logic        pc_update,
  input  logic [1:0]  pc_next_sel,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] imm_sext,
  output logic [25:0] target,
  output logic [3:0]  cmd,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [3:0]  w_cmd;
  logic        w_illegal;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_ISSUE;
      S_ISSUE: if (ctrl_ready) w_next_state = S_EXEC;
      S_EXEC:  if (pc_update)  w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Instruction register, captured in LOAD from the registered memory read
  always_ff @(posedge clk) begin
    if (reset)                  r_ir <= '0;
    else if (r_state == S_LOAD) r_ir <= imem_rdata;
  end

  // Program counter, updated only when the controller retires in EXEC
  always_ff @(posedge clk) begin
    if (reset)                               r_pc <= RESET_PC;
    else if (r_state == S_EXEC && pc_update) r_pc <= w_pc_next;
  end

  // Next-PC selection
  always_comb begin
    w_pc_next = pc_plus4;
    case (pc_next_sel)
      2'b00: w_pc_next = pc_plus4;
      2'b01: w_pc_next = {pc_plus4[31:28], r_ir[25:0], 2'b00};
      2'b10: w_pc_next = rs_value & 32'hFFFF_FFFC;
      2'b11: w_pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
      default: w_pc_next = pc_plus4;
    endcase
  end

  // Command decode from opcode, or funct for R-type
  always_comb begin
    w_cmd     = 4'd15;
    w_illegal = 1'b1;
    case (r_ir[31:26])
      6'h23: begin w_cmd = 4'd0; w_illegal = 1'b0; end
      6'h2B: begin w_cmd = 4'd1; w_illegal = 1'b0; end
      6'h02: begin w_cmd = 4'd2; w_illegal = 1'b0; end
      6'h03: begin w_cmd = 4'd4; w_illegal = 1'b0; end
      6'h05: begin w_cmd = 4'd5; w_illegal = 1'b0; end
      6'h0E: begin w_cmd = 4'd6; w_illegal = 1'b0; end
      6'h08: begin w_cmd = 4'd8; w_illegal = 1'b0; end
      6'h00: begin
        case (r_ir[5:0])
          6'h08: begin w_cmd = 4'd3;  w_illegal = 1'b0; end
          6'h20: begin w_cmd = 4'd7;  w_illegal = 1'b0; end
          6'h22: begin w_cmd = 4'd9;  w_illegal = 1'b0; end
          6'h2A: begin w_cmd = 4'd10; w_illegal = 1'b0; end
          default: begin w_cmd = 4'd15; w_illegal = 1'b1; end
        endcase
      end
      default: begin w_cmd = 4'd15; w_illegal = 1'b1; end
    endcase
  end

  // State-dependent outputs; read strobe is suppressed while reset is held
  always_comb begin
    imem_rd_en  = (r_state == S_FETCH) && !reset;
    instr_valid = (r_state == S_ISSUE);
    if (r_state == S_ISSUE || r_state == S_EXEC) begin
      cmd     = w_cmd;
      illegal = w_illegal;
    end else begin
      cmd     = 4'd0;
      illegal = 1'b0;
    end
  end

  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign pc_plus4  = r_pc + 32'd4;
  assign opcode    = r_ir[31:26];
  assign rs        = r_ir[25:21];
  assign rt        = r_ir[20:16];
  assign rd        = r_ir[15:11];
  assign funct     = r_ir[5:0];
  assign imm16     = r_ir[15:0];
  assign imm_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign target    = r_ir[25:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a registered instruction memory.
module tb_instr_fetch_decode;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        ctrl_ready;
  logic        pc_update;
  logic [1:0]  pc_next_sel;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] imm_sext;
  logic [25:0] target;
  logic [3:0]  cmd;
  logic        illegal;

  int unsigned n_vec;
  int unsigned n_err;

  logic [31:0] mem [int unsigned];

  instr_fetch_decode #(.RESET_PC(32'h0000_0040)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .ctrl_ready(ctrl_ready),
    .pc_update(pc_update), .pc_next_sel(pc_next_sel), .rs_value(rs_value),
    .pc(pc), .pc_plus4(pc_plus4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm16(imm16), .imm_sext(imm_sext), .target(target),
    .cmd(cmd), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data the cycle after the read strobe; unwritten words read 0
  always @(posedge clk) begin
    if (imem_rd_en)
      imem_rdata <= mem.exists(imem_addr) ? mem[imem_addr] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction at minimum period; entry and exit are in a FETCH cycle
  task automatic run_instr(input logic [31:0] a, input logic [3:0] c, input logic il,
                           input logic [1:0] sel, input logic [31:0] rv);
    chk("fetch_rd_en", {31'b0, imem_rd_en}, 32'd1);
    chk("fetch_addr", imem_addr, a);
    chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
    ctrl_ready = 1'b1;
    pc_update  = 1'b0;
    step();
    chk("load_valid", {31'b0, instr_valid}, 32'd0);
    chk("load_cmd", {28'b0, cmd}, 32'd0);
    chk("load_rd_en", {31'b0, imem_rd_en}, 32'd0);
    step();
    chk("issue_valid", {31'b0, instr_valid}, 32'd1);
    chk("issue_cmd", {28'b0, cmd}, {28'b0, c});
    chk("issue_illegal", {31'b0, illegal}, {31'b0, il});
    chk("issue_pc_plus4", pc_plus4, a + 32'd4);
    pc_update   = 1'b1;
    pc_next_sel = sel;
    rs_value    = rv;
    step();
    chk("exec_valid", {31'b0, instr_valid}, 32'd0);
    chk("exec_pc", pc, a);
    chk("exec_cmd", {28'b0, cmd}, {28'b0, c});
    step();
    pc_update   = 1'b0;
    rs_value    = 32'hDEAD_BEEF;
    pc_next_sel = 2'b00;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [3:0]  c;
    logic        il;
  } vec_t;

  vec_t tbl[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    mem[32'h40]   = 32'h8C22_0004; // lw   $2, 4($1)
    mem[32'h44]   = 32'h0040_0008; // jr   $2
    mem[32'h1234] = 32'h0800_0040; // j    0x100
    mem[32'h100]  = 32'h1422_FFFF; // bne  -1
    mem[32'h104]  = 32'h0800_0080; // j    0x200
    mem[32'h200]  = 32'h0800_0010; // j    0x40
    tbl.push_back('{32'hAC22_0008, 4'd1,  1'b0}); // sw
    tbl.push_back('{32'h0C00_0000, 4'd4,  1'b0}); // jal
    tbl.push_back('{32'h3822_000F, 4'd6,  1'b0}); // xori
    tbl.push_back('{32'h0022_1820, 4'd7,  1'b0}); // add
    tbl.push_back('{32'h2022_FFF0, 4'd8,  1'b0}); // addi
    tbl.push_back('{32'h0022_1822, 4'd9,  1'b0}); // sub
    tbl.push_back('{32'h0022_182A, 4'd10, 1'b0}); // slt
    tbl.push_back('{32'h0022_1821, 4'd15, 1'b1}); // addu
    tbl.push_back('{32'h1022_0000, 4'd15, 1'b1}); // beq
    foreach (tbl[i]) mem[32'h300 + 4 * i] = tbl[i].word;

    reset       = 1'b1;
    ctrl_ready  = 1'b0;
    pc_update   = 1'b0;
    pc_next_sel = 2'b00;
    rs_value    = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h40);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_cmd", {28'b0, cmd}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_rd_en", {31'b0, imem_rd_en}, 32'd0);
    chk("rst_ir", {opcode, target}, 32'h0);
    reset = 1'b0;
    #1;

    run_instr(32'h40, 4'd0, 1'b0, 2'b00, 32'h0);
    chk("lw_opcode", {26'b0, opcode}, 32'h23);
    chk("lw_rs", {27'b0, rs}, 32'd1);
    chk("lw_rt", {27'b0, rt}, 32'd2);
    chk("lw_imm_sext", imm_sext, 32'd4);
    run_instr(32'h44, 4'd3, 1'b0, 2'b10, 32'h0000_1237);
    chk("jr_funct", {26'b0, funct}, 32'h08);
    run_instr(32'h1234, 4'd2, 1'b0, 2'b01, 32'h0);
    run_instr(32'h100, 4'd5, 1'b0, 2'b11, 32'h0);
    chk("bne_imm_sext", imm_sext, 32'hFFFF_FFFF);
    run_instr(32'h100, 4'd5, 1'b0, 2'b00, 32'h0);
    run_instr(32'h104, 4'd2, 1'b0, 2'b01, 32'h0);

    // Stall in ISSUE for three cycles, with a stray pc_update pulse
    chk("stall_addr", imem_addr, 32'h200);
    ctrl_ready = 1'b0;
    step();
    step();
    chk("stall_issue_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_issue_cmd", {28'b0, cmd}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      pc_update   = (i == 0);
      pc_next_sel = 2'b11;
      step();
      chk("stall_hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_hold_target", {6'b0, target}, 32'h10);
      chk("stall_hold_pc", pc, 32'h200);
    end
    pc_update  = 1'b0;
    ctrl_ready = 1'b1;
    step();
    chk("stall_exec_valid", {31'b0, instr_valid}, 32'd0);
    ctrl_ready = 1'b0;
    step();
    chk("exec_hold_pc", pc, 32'h200);
    chk("exec_hold_rd_en", {31'b0, imem_rd_en}, 32'd0);
    chk("exec_hold_cmd", {28'b0, cmd}, 32'd2);
    pc_update   = 1'b1;
    pc_next_sel = 2'b01;
    step();
    pc_update = 1'b0;
    chk("j_pc", pc, 32'h40);

    // Branch-style target from lw's immediate: 0x44 + (4 << 2) = 0x54
    run_instr(32'h40, 4'd0, 1'b0, 2'b11, 32'h0);

    // Illegal word (0 = sll), then reset while in EXEC
    chk("sll_addr", imem_addr, 32'h54);
    ctrl_ready = 1'b1;
    step();
    step();
    chk("sll_cmd", {28'b0, cmd}, 32'd15);
    chk("sll_illegal", {31'b0, illegal}, 32'd1);
    chk("sll_valid", {31'b0, instr_valid}, 32'd1);
    step();
    chk("sll_exec_illegal", {31'b0, illegal}, 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_pc", pc, 32'h40);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_cmd", {28'b0, cmd}, 32'd0);
    chk("mid_rst_illegal", {31'b0, illegal}, 32'd0);
    chk("mid_rst_rd_en", {31'b0, imem_rd_en}, 32'd0);
    reset = 1'b0;
    #1;

    // Jump via register into the decode table, then walk it at minimum period
    run_instr(32'h40, 4'd0, 1'b0, 2'b10, 32'h0000_0300);
    foreach (tbl[i]) begin
      run_instr(32'h300 + 4 * i, tbl[i].c, tbl[i].il, 2'b00, 32'h0);
      if (i == 4) chk("addi_imm_sext", imm_sext, 32'hFFFF_FFF0);
    end
    chk("table_end_addr", imem_addr, 32'h300 + 4 * 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
